// File: rtl/controller_seq_if.sv
// Bus-side signal bundle of the BatAmateur microcode sequencer.
// master: the sequencer (consumes IR/flags/ready, drives the strobes).
// slave : the datapath side (PC, MAR, RAM, IR, register file, ALU).
`timescale 1ns/1ps
interface controller_seq_if #(
  parameter int NUM_REGS = 8,
  parameter int ALU_OP_W = 5
);
  logic [15:0]         instr;
  logic                zero_flag;
  logic                cin_flag;
  logic                mem_ready;
  logic                pc_inc, pc_rw, pc_en;
  logic                mar_load, mar_en;
  logic                ram_rw, ram_en;
  logic                ir_load, ir_en;
  logic                alu_en;
  logic [NUM_REGS-1:0] regs_inc, regs_rw, regs_en;
  logic [ALU_OP_W-1:0] alu_op;

  modport master (
    input  instr, zero_flag, cin_flag, mem_ready,
    output pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en,
           ir_load, ir_en, alu_en, regs_inc, regs_rw, regs_en, alu_op
  );

  modport slave (
    output instr, zero_flag, cin_flag, mem_ready,
    input  pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en,
           ir_load, ir_en, alu_en, regs_inc, regs_rw, regs_en, alu_op
  );
endinterface

// File: rtl/controller_seq.sv
// Microcode sequencer for the BatAmateur CPU: micro-step counter, flag
// register and RAM wait handshake. Control strobes are decoded
// combinationally from (step, IR, registered Z flag).
// Optional feature macro: CTRL_SINGLE_STEP_EN adds step_req/halted for
// one-instruction-at-a-time execution.
`timescale 1ns/1ps
module controller_seq #(
  parameter int NUM_REGS = 8,
  parameter int ALU_OP_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step_req,
  output logic             halted,
`endif
  controller_seq_if.master bus,
  output logic [2:0]       uop,
  output logic             flag_z,
  output logic             flag_c,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EX2    = 3'd2,
    S_EX3    = 3'd3,
    S_EX4    = 3'd4,
    S_EX5    = 3'd5,
    S_IDLE   = 3'd7
  } step_e;

  typedef struct packed {
    logic                pc_inc, pc_rw, pc_en;
    logic                mar_load, mar_en;
    logic                ram_rw, ram_en;
    logic                ir_load, ir_en;
    logic                alu_en;
    logic [NUM_REGS-1:0] regs_inc, regs_rw, regs_en;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // One-hot register select; indices past the file never produce a bit.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [2:0] idx);
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(idx) == i) r[i] = 1'b1;
    return r;
  endfunction

  // RAM <-> accumulator transfer (final step of every LD/ST form).
  function automatic ctrl_t mem_xfer(input ctrl_t w, input logic st,
                                     input logic [NUM_REGS-1:0] r);
    ctrl_t o;
    o = w;
    o.ram_en  = 1'b1;
    o.regs_en = r;
    if (st) begin
      o.ram_rw  = 1'b0;
      o.regs_rw = r;
    end else begin
      o.regs_rw = '0;
    end
    return o;
  endfunction

  step_e               state;
  ctrl_t               cw;
  logic                last, ill_now, flag_cap, stall, hold0;
  logic [3:0]          opc;
  logic [4:0]          fn;
  logic [2:0]          op1, op2;
  logic                taken, bad;
  logic [NUM_REGS-1:0] acc_bit, dst_bit, op1_bit, op2_bit, a_bit, b_bit;

  assign opc     = bus.instr[15:12];
  assign fn      = bus.instr[11:7];
  assign op1     = bus.instr[5:3];
  assign op2     = bus.instr[2:0];
  assign acc_bit = reg_bit({2'b00, opc[0]});
  assign dst_bit = reg_bit({2'b00, bus.instr[6]});
  assign op1_bit = reg_bit(op1);
  assign op2_bit = reg_bit(op2);
  assign a_bit   = reg_bit(3'd0);
  assign b_bit   = reg_bit(3'd1);
  // Low two opcode bits select JMP/JZ/JNZ for both direct and indirect forms.
  assign taken   = (opc[1:0] == 2'b00) |
                   ((opc[1:0] == 2'b01) &  flag_z) |
                   ((opc[1:0] == 2'b10) & ~flag_z);
  assign bad     = (int'(op1) >= NUM_REGS) || (int'(op2) >= NUM_REGS);

`ifdef CTRL_SINGLE_STEP_EN
  assign hold0 = halted && (state == S_FETCH);
`else
  assign hold0 = 1'b0;
`endif

  // Control word decode; starts from the idle word and adds the step's strobes.
  always_comb begin
    cw          = '0;
    cw.pc_rw    = 1'b1;
    cw.ram_rw   = 1'b1;
    cw.mar_en   = 1'b1;
    cw.regs_rw  = '1;
    last        = 1'b0;
    ill_now     = 1'b0;
    flag_cap    = 1'b0;
    case (state)
      S_FETCH: if (!hold0) begin
        cw.pc_en    = 1'b1;
        cw.mar_load = 1'b1;
      end
      S_DECODE: begin
        cw.ram_en  = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      S_IDLE: ;
      default: begin
        last = 1'b1;
        casez (opc)
          4'b00??: begin            // LD/ST direct
            if (state == S_EX2) begin
              cw.ir_en = 1'b1; cw.mar_load = 1'b1; last = 1'b0;
            end else if (state == S_EX3) begin
              cw = mem_xfer(cw, opc[1], acc_bit);
            end
          end
          4'b10??: begin            // LD/ST indirect
            if (state == S_EX2) begin
              cw.ir_en = 1'b1; cw.mar_load = 1'b1; last = 1'b0;
            end else if (state == S_EX3) begin
              cw.ram_en = 1'b1; cw.mar_load = 1'b1; last = 1'b0;
            end else if (state == S_EX4) begin
              cw = mem_xfer(cw, opc[1], acc_bit);
            end
          end
          4'b0100, 4'b0101, 4'b0110: begin  // direct jumps
            cw.pc_rw = 1'b0;
            if (taken) begin
              cw.pc_en = 1'b1; cw.ir_en = 1'b1;
            end
          end
          4'b1100, 4'b1101, 4'b1110: begin  // indirect jumps
            if (state == S_EX2) begin
              cw.ir_en = 1'b1; cw.mar_load = 1'b1; last = 1'b0;
            end else if (state == S_EX3 && taken) begin
              cw.ram_en = 1'b1; cw.pc_en = 1'b1; cw.pc_rw = 1'b0;
            end
          end
          4'b0111: begin
            if (bad) begin
              // Out-of-range operand: drop the instruction, write nothing.
              ill_now = (state == S_EX2);
            end else if (fn == 5'h1F) begin
              cw.regs_en = op1_bit | op2_bit;
              cw.regs_rw = op2_bit;
            end else begin
              cw.alu_op = ALU_OP_W'(fn);
              case (state)
                S_EX2: begin
                  cw.regs_en = a_bit | op1_bit; cw.regs_rw = op1_bit; last = 1'b0;
                end
                S_EX3: begin
                  cw.regs_en = b_bit | op2_bit; cw.regs_rw = op2_bit; last = 1'b0;
                end
                S_EX4: begin
                  cw.alu_en = 1'b1; cw.regs_en = dst_bit; cw.regs_rw = '0; last = 1'b0;
                end
                S_EX5: begin
                  cw.alu_en = 1'b1; flag_cap = 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: ;                // NOP
        endcase
      end
    endcase
  end

  // Any RAM access stretches its step until the RAM reports completion.
  assign stall = cw.ram_en & ~bus.mem_ready;

  // Step counter, flags, illegal pulse and single-step halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
      halted  <= 1'b1;
`endif
    end else begin
      illegal <= ill_now;
      if (flag_cap) begin
        flag_z <= bus.zero_flag;
        flag_c <= bus.cin_flag;
      end
      if (state == S_IDLE)
        state <= S_FETCH;
      else if (!stall && !hold0)
        state <= last ? S_FETCH : step_e'(state + 3'd1);
`ifdef CTRL_SINGLE_STEP_EN
      if (halted) begin
        if (step_req) halted <= 1'b0;
      end else if (!stall && last) begin
        halted <= 1'b1;
      end
`endif
    end
  end

  assign uop          = state;
  assign bus.pc_inc   = cw.pc_inc;
  assign bus.pc_rw    = cw.pc_rw;
  assign bus.pc_en    = cw.pc_en;
  assign bus.mar_load = cw.mar_load;
  assign bus.mar_en   = cw.mar_en;
  assign bus.ram_rw   = cw.ram_rw;
  assign bus.ram_en   = cw.ram_en;
  assign bus.ir_load  = cw.ir_load;
  assign bus.ir_en    = cw.ir_en;
  assign bus.alu_en   = cw.alu_en;
  assign bus.regs_inc = cw.regs_inc;
  assign bus.regs_rw  = cw.regs_rw;
  assign bus.regs_en  = cw.regs_en;
  assign bus.alu_op   = cw.alu_op;

endmodule

// File: tb/tb_controller_seq.sv
// Bench for controller_seq: directed scenarios plus random instructions,
// checked against a register-transfer model of each instruction.
`timescale 1ns/1ps
module tb_controller_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  controller_seq_if #(.NUM_REGS(8), .ALU_OP_W(5)) bus ();
  controller_seq_if #(.NUM_REGS(4), .ALU_OP_W(5)) bus4 ();
  logic [2:0] uop, uop4;
  logic flag_z, flag_c, illegal, flag_z4, flag_c4, illegal4;
`ifdef CTRL_SINGLE_STEP_EN
  logic step_req = 1'b0, step_req4 = 1'b0, halted, halted4;
`endif

  controller_seq #(.NUM_REGS(8), .ALU_OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step_req(step_req), .halted(halted),
`endif
    .bus(bus), .uop(uop), .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal));

  controller_seq #(.NUM_REGS(4), .ALU_OP_W(5)) dut4 (
    .clk(clk), .rst_n(rst4_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step_req(step_req4), .halted(halted4),
`endif
    .bus(bus4), .uop(uop4), .flag_z(flag_z4), .flag_c(flag_c4), .illegal(illegal4));

  typedef struct packed {
    logic       pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en, ir_load, ir_en, alu_en;
    logic [7:0] regs_inc, regs_rw, regs_en;
    logic [4:0] alu_op;
  } cw_t;

  // Bus units for the transfer model; 0..7 are register indices.
  localparam int PC = 8, MAR = 9, RAM = 10, IR = 11, ALU = 12;

  int   errs = 0, checks = 0;
  cw_t  exp_q[$];
  bit   is_alu;
  logic mflag_z = 1'b0, mflag_c = 1'b0;
  bit   rdy_rand = 0;
  int   stall_step = -1, stall_n = 0, stalled = 0, fz_mode = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cw_t idle_w();
    cw_t w;
    w = '0;
    w.pc_rw = 1'b1; w.ram_rw = 1'b1; w.mar_en = 1'b1; w.regs_rw = '1;
    return w;
  endfunction

  // One bus transfer src -> dst expressed as strobes (RW: 1 drive, 0 load).
  function automatic cw_t xfer(input int src, input int dst);
    cw_t w;
    w = idle_w();
    if (src < 8 || dst < 8) w.regs_rw = '0;
    case (src)
      PC:  w.pc_en = 1'b1;
      RAM: w.ram_en = 1'b1;
      IR:  w.ir_en = 1'b1;
      ALU: w.alu_en = 1'b1;
      default: if (src < 8) begin w.regs_en[src] = 1'b1; w.regs_rw[src] = 1'b1; end
    endcase
    case (dst)
      PC:  begin w.pc_en = 1'b1; w.pc_rw = 1'b0; end
      MAR: w.mar_load = 1'b1;
      RAM: begin w.ram_en = 1'b1; w.ram_rw = 1'b0; end
      IR:  w.ir_load = 1'b1;
      default: if (dst < 8) w.regs_en[dst] = 1'b1;
    endcase
    return w;
  endfunction

  // Expected per-step control words of one instruction.
  function automatic void build(input logic [15:0] ins, input logic fz);
    cw_t w;
    int opc, aop, o1, o2, r;
    bit tk;
    opc = int'(ins[15:12]); aop = int'(ins[11:7]);
    o1 = int'(ins[5:3]); o2 = int'(ins[2:0]); r = opc % 2;
    tk = (opc % 4 == 0) || (opc % 4 == 1 && fz) || (opc % 4 == 2 && !fz);
    exp_q.delete();
    is_alu = 0;
    exp_q.push_back(xfer(PC, MAR));
    w = xfer(RAM, IR); w.pc_inc = 1'b1; exp_q.push_back(w);
    if (opc <= 1) begin
      exp_q.push_back(xfer(IR, MAR)); exp_q.push_back(xfer(RAM, r));
    end else if (opc <= 3) begin
      exp_q.push_back(xfer(IR, MAR)); exp_q.push_back(xfer(r, RAM));
    end else if (opc >= 8 && opc <= 11) begin
      exp_q.push_back(xfer(IR, MAR)); exp_q.push_back(xfer(RAM, MAR));
      exp_q.push_back((opc >= 10) ? xfer(r, RAM) : xfer(RAM, r));
    end else if (opc >= 4 && opc <= 6) begin
      if (tk) exp_q.push_back(xfer(IR, PC));
      else begin w = idle_w(); w.pc_rw = 1'b0; exp_q.push_back(w); end
    end else if (opc >= 12 && opc <= 14) begin
      exp_q.push_back(xfer(IR, MAR));
      exp_q.push_back(tk ? xfer(RAM, PC) : idle_w());
    end else if (opc == 7 && aop == 31) begin
      exp_q.push_back(xfer(o2, o1));
    end else if (opc == 7) begin
      is_alu = 1;
      w = xfer(o1, 0);       w.alu_op = 5'(aop); exp_q.push_back(w);
      w = xfer(o2, 1);       w.alu_op = 5'(aop); exp_q.push_back(w);
      w = xfer(ALU, ins[6]); w.alu_op = 5'(aop); exp_q.push_back(w);
      w = idle_w(); w.alu_en = 1'b1; w.alu_op = 5'(aop); exp_q.push_back(w);
    end else begin
      exp_q.push_back(idle_w());
    end
  endfunction

  function automatic cw_t dut_w();
    cw_t w;
    w.pc_inc = bus.pc_inc; w.pc_rw = bus.pc_rw; w.pc_en = bus.pc_en;
    w.mar_load = bus.mar_load; w.mar_en = bus.mar_en;
    w.ram_rw = bus.ram_rw; w.ram_en = bus.ram_en;
    w.ir_load = bus.ir_load; w.ir_en = bus.ir_en; w.alu_en = bus.alu_en;
    w.regs_inc = bus.regs_inc; w.regs_rw = bus.regs_rw; w.regs_en = bus.regs_en;
    w.alu_op = bus.alu_op;
    return w;
  endfunction

  // Runs one instruction from step 0; abort_at >= 0 resets at that step.
  task automatic run_instr(input logic [15:0] ins, input int abort_at);
    int k, guard;
    logic rdy, zf, cf;
    build(ins, mflag_z);
    bus.instr = ins;
`ifdef CTRL_SINGLE_STEP_EN
    @(negedge clk);
    chk("halted", 64'(halted), 64'(1));
    chk("halt uop", 64'(uop), 64'(0));
    chk("halt word", 64'(dut_w()), 64'(idle_w()));
    step_req = 1'b1; @(posedge clk); #1 step_req = 1'b0;
`endif
    k = 0; guard = 0; stalled = 0;
    while (k < exp_q.size() && guard < 64) begin
      rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k == stall_step && stalled < stall_n) begin rdy = 1'b0; stalled++; end
      zf = (fz_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(fz_mode);
      cf = 1'($urandom_range(0, 1));
      bus.mem_ready = rdy; bus.zero_flag = zf; bus.cin_flag = cf;
      @(negedge clk);
      chk($sformatf("uop %h", ins), 64'(uop), 64'(k));
      chk($sformatf("word %h s%0d", ins, k), 64'(dut_w()), 64'(exp_q[k]));
      chk("flag_z", 64'(flag_z), 64'(mflag_z));
      chk("flag_c", 64'(flag_c), 64'(mflag_c));
      chk("illegal", 64'(illegal), 64'(0));
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort uop", 64'(uop), 64'(7));
        chk("abort ram_en", 64'(bus.ram_en), 64'(0));
        chk("abort word", 64'(dut_w()), 64'(idle_w()));
        chk("abort flag_z", 64'(flag_z), 64'(0));
        mflag_z = 1'b0; mflag_c = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (!(exp_q[k].ram_en && !rdy)) begin
        if (is_alu && k == 5) begin mflag_z = zf; mflag_c = cf; end
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 64) begin
      checks++; errs++;
      $error("FAIL timeout %h: stuck at step %0d, wanted %0d steps", ins, k, exp_q.size());
    end
  endtask

  initial begin
    bus.instr = 16'h0; bus.mem_ready = 1'b1; bus.zero_flag = 1'b0; bus.cin_flag = 1'b0;
    bus4.instr = 16'h7FB1; bus4.mem_ready = 1'b1; bus4.zero_flag = 1'b0; bus4.cin_flag = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset uop", 64'(uop), 64'(7));
    chk("reset word", 64'(dut_w()), 64'(idle_w()));
    chk("reset flag_z", 64'(flag_z), 64'(0));
    chk("reset flag_c", 64'(flag_c), 64'(0));
    chk("reset illegal", 64'(illegal), 64'(0));
`ifdef CTRL_SINGLE_STEP_EN
    chk("reset halted", 64'(halted), 64'(1));
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef CTRL_SINGLE_STEP_EN
    // No progress without a step request
    repeat (4) begin
      @(negedge clk);
      chk("hold uop", 64'(uop), 64'(0));
      chk("hold word", 64'(dut_w()), 64'(idle_w()));
      @(posedge clk); #1;
    end
    run_instr(16'hF000, -1);
    repeat (3) begin
      @(negedge clk);
      chk("rehalt uop", 64'(uop), 64'(0));
      chk("rehalt", 64'(halted), 64'(1));
      @(posedge clk); #1;
    end
`endif

    // LDA, then LDA with three wait cycles in s3
    run_instr(16'h0005, -1);
    stall_step = 3; stall_n = 3;
    run_instr(16'h0005, -1);
    stall_step = -1;

    // ALU op1=3 op2=4 with live zero, then taken JZ
    fz_mode = 1;
    run_instr(16'h701C, -1);
    run_instr(16'h5010, -1);

    // Not-taken JNZ (direct and indirect) with RAM not ready in the execute step
    stall_step = 2; stall_n = 4;
    run_instr(16'h6000, -1);
    stall_step = 3;
    run_instr(16'hE000, -1);
    stall_step = -1;

    // Reset in s4 of indirect store ST A
    run_instr(16'hA000, 4);
    fz_mode = -1;

    // Random instruction stream with random RAM readiness and live flags
    rdy_rand = 1;
    repeat (150) run_instr(16'($urandom), -1);
    rdy_rand = 0;

    // NUM_REGS=4: MOV with op1=6 is illegal
    @(posedge clk); #1 rst4_n = 1'b1;
    @(posedge clk); #1;
`ifdef CTRL_SINGLE_STEP_EN
    step_req4 = 1'b1; @(posedge clk); #1 step_req4 = 1'b0;
`endif
    @(negedge clk); chk("r4 uop s0", 64'(uop4), 64'(0));
    @(negedge clk); chk("r4 uop s1", 64'(uop4), 64'(1));
    @(negedge clk);
    chk("r4 uop s2", 64'(uop4), 64'(2));
    chk("r4 regs_en", 64'(bus4.regs_en), 64'(0));
    chk("r4 regs_rw", 64'(bus4.regs_rw), 64'(4'hF));
    chk("r4 ram_en", 64'(bus4.ram_en), 64'(0));
    chk("r4 alu_en", 64'(bus4.alu_en), 64'(0));
    @(negedge clk);
    chk("r4 next uop", 64'(uop4), 64'(0));
    chk("r4 illegal", 64'(illegal4), 64'(1));
    chk("r4 flag_z", 64'(flag_z4), 64'(0));
    @(negedge clk);
    chk("r4 illegal end", 64'(illegal4), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
